// File: rtl/lfsr_stream_arbiter.sv
// Round-robin arbiter that shares one Fibonacci LFSR and serialises WORD_W-bit words per grant.
// Optional all-zero lockup recovery is enabled by defining LFSR_LOCKUP_RECOVERY_EN.
module lfsr_stream_arbiter #(
    parameter int unsigned       N_REQ        = 4,
    parameter int unsigned       LFSR_W       = 4,
    parameter logic [LFSR_W-1:0] TAPS         = 4'b1001,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = 4'b0001,
    parameter int unsigned       WORD_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  grant,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] lfsr_state,
    output logic              busy,
    output logic              lockup
);
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, GEN, HOLD} state_e;

    state_e             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [CNT_W-1:0]   cnt;
    logic [LFSR_W-1:0]  lfsr;
    logic [LFSR_W-1:0]  lfsr_step;
    logic [WORD_W-1:0]  word;
    logic [WORD_W-1:0]  word_step;
    logic               lfsr_zero;
    logic               owner_req;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    int unsigned        j;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = (32'(ptr) + k) % N_REQ;
            if (!pick_found && req[j[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = j[IDX_W-1:0];
            end
        end
    end

`ifdef LFSR_LOCKUP_RECOVERY_EN
    assign lfsr_zero = (lfsr == '0);
`else
    assign lfsr_zero = 1'b0;
`endif

    assign lfsr_step  = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    assign word_step  = {word[WORD_W-2:0], lfsr[LFSR_W-1]};
    assign idx_next   = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
    assign owner_req  = |(req & grant);
    assign out_data   = word;
    assign lfsr_state = lfsr;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            cnt       <= '0;
            lfsr      <= SEED_DEFAULT;
            word      <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            lockup    <= 1'b0;
        end else if (seed_load) begin
            lfsr      <= seed;
            state     <= IDLE;
            grant     <= '0;
            out_valid <= 1'b0;
            lockup    <= 1'b0;
            if (state != IDLE) ptr <= idx_next;
        end else begin
            lockup <= 1'b0;
            if (lfsr_zero) begin
                lfsr   <= SEED_DEFAULT;
                lockup <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        idx   <= pick_idx;
                        word  <= '0;
                        cnt   <= '0;
                        state <= GEN;
                    end
                end
                GEN: begin
                    if (!owner_req) begin
                        grant <= '0;
                        ptr   <= idx_next;
                        state <= IDLE;
                    end else begin
                        // A lockup reload replaces the step but still consumes a word bit.
                        if (!lfsr_zero) lfsr <= lfsr_step;
                        word <= word_step;
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WORD_W - 1)) begin
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!owner_req || out_ready) begin
                        grant     <= '0;
                        out_valid <= 1'b0;
                        ptr       <= idx_next;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_stream_arbiter.sv
// Directed and random checks of lfsr_stream_arbiter against a transaction-level reference model.
module tb_lfsr_stream_arbiter;
    localparam int         N        = 4;
    localparam logic [3:0] TAPS     = 4'b1001;
    localparam logic [3:0] SEED_DEF = 4'b0001;
`ifdef LFSR_LOCKUP_RECOVERY_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, out_ready, seed_load;
    logic       out_valid, busy, lockup;
    logic [3:0] req, grant, out_data, seed, lfsr_state;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 idle, 1 generating, 2 holding; owner -1 when nobody granted.
    int         m_phase, m_owner, m_ptr, m_steps;
    logic [3:0] m_lfsr, m_word;
    logic       m_valid, m_lock;

    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    lfsr_stream_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .grant      (grant),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .seed_load  (seed_load),
        .seed       (seed),
        .lfsr_state (lfsr_state),
        .busy       (busy),
        .lockup     (lockup)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int         n_phase, n_owner, n_ptr, n_steps;
        logic [3:0] n_lfsr, n_word;
        logic       n_valid, n_lock, zero, fb, held;
        logic [3:0] m_grant;
        n_phase = m_phase; n_owner = m_owner; n_ptr = m_ptr; n_steps = m_steps;
        n_lfsr = m_lfsr; n_word = m_word; n_valid = m_valid; n_lock = 1'b0;
        if (reset) begin
            n_phase = 0; n_owner = -1; n_ptr = 0; n_steps = 0;
            n_lfsr = SEED_DEF; n_word = 4'b0000; n_valid = 1'b0;
        end else if (seed_load) begin
            if (m_phase != 0) n_ptr = (m_owner + 1) % N;
            n_phase = 0; n_owner = -1; n_valid = 1'b0; n_lfsr = seed;
        end else begin
            zero = LOCK_EN && (m_lfsr == 4'b0000);
            if (zero) begin
                n_lfsr = SEED_DEF;
                n_lock = 1'b1;
            end
            held = (m_owner >= 0) && req[m_owner];
            if (m_phase == 0) begin
                for (int i = 0; i < N; i++) begin
                    if (req[(m_ptr + i) % N]) begin
                        n_owner = (m_ptr + i) % N;
                        break;
                    end
                end
                if (req != 4'b0000) begin
                    n_phase = 1; n_word = 4'b0000; n_steps = 0;
                end
            end else if (!held || (m_phase == 2 && out_ready)) begin
                n_ptr = (m_owner + 1) % N;
                n_phase = 0; n_owner = -1; n_valid = 1'b0;
            end else if (m_phase == 1) begin
                n_word = {m_word[2:0], m_lfsr[3]};
                fb = ($countones(m_lfsr & TAPS) % 2) == 1;
                if (!zero) n_lfsr = {m_lfsr[2:0], fb};
                n_steps = n_steps + 1;
                if (n_steps == 4) begin
                    n_phase = 2; n_valid = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_phase = n_phase; m_owner = n_owner; m_ptr = n_ptr; m_steps = n_steps;
        m_lfsr = n_lfsr; m_word = n_word; m_valid = n_valid; m_lock = n_lock;
        m_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check("grant", grant, m_grant);
        check("out_data", out_data, m_word);
        check("out_valid", out_valid, m_valid);
        check("lfsr_state", lfsr_state, m_lfsr);
        check("busy", busy, m_phase != 0);
        check("lockup", lockup, m_lock);
        check("onehot", $countones(grant) <= 1, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 4'b0000; out_ready = 1'b0; seed_load = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 20; c++) begin
            if (out_valid === 1'b1) break;
            tick();
        end
        check("wait_valid", out_valid, 1);
    endtask

    initial begin
        int         got;
        logic [3:0] prev;
        reset = 1'b1; req = 4'b0000; out_ready = 1'b0; seed_load = 1'b0; seed = 4'b0000;
        tick();
        tick();
        check("rst_lfsr", lfsr_state, 4'b0001);
        check("rst_grant", grant, 4'b0000);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // Single transaction latency and value
        req = 4'b0001;
        tick();
        check("t1_grant", grant, 4'b0001);
        repeat (3) tick();
        check("t1_early", out_valid, 0);
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 4'b0001);
        check("t1_lfsr", lfsr_state, 4'b1110);
        out_ready = 1'b1;
        tick();
        check("t1_accept", out_valid, 0);

        // Round-robin order with all requesters active
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        got = 0; prev = 4'b0000;
        for (int c = 0; c < 60 && got < 5; c++) begin
            tick();
            if (grant != 4'b0000 && prev == 4'b0000) begin
                check("t2_order", grant, exp_seq[got]);
                got++;
            end
            prev = grant;
        end
        check("t2_count", got, 5);

        // Backpressure in HOLD
        do_reset();
        req = 4'b0100; out_ready = 1'b0;
        wait_valid();
        repeat (10) begin
            tick();
            check("t3_valid", out_valid, 1);
            check("t3_data", out_data, 4'b0001);
            check("t3_lfsr", lfsr_state, 4'b1110);
            check("t3_grant", grant, 4'b0100);
        end
        out_ready = 1'b1;
        tick();
        check("t3_accept", out_valid, 0);
        check("t3_release", grant, 4'b0000);

        // Seed load during the second GEN cycle
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        seed_load = 1'b1; seed = 4'b1000;
        tick();
        seed_load = 1'b0;
        check("t4_grant", grant, 4'b0000);
        check("t4_valid", out_valid, 0);
        check("t4_lfsr", lfsr_state, 4'b1000);
        check("t4_busy", busy, 0);
        req = 4'b0011;
        tick();
        check("t4_next", grant, 4'b0010);
        out_ready = 1'b1;
        wait_valid();
        tick();
        req = 4'b0000; out_ready = 1'b0;
        tick();

        // Zero seed
        do_reset();
        seed_load = 1'b1; seed = 4'b0000;
        tick();
        seed_load = 1'b0;
        check("t5_load", lfsr_state, 4'b0000);
        tick();
`ifdef LFSR_LOCKUP_RECOVERY_EN
        check("t5_recover", lfsr_state, 4'b0001);
        check("t5_pulse", lockup, 1);
`else
        check("t5_stuck", lfsr_state, 4'b0000);
        check("t5_nopulse", lockup, 0);
`endif
        req = 4'b0001;
        wait_valid();
`ifndef LFSR_LOCKUP_RECOVERY_EN
        check("t5_word", out_data, 4'b0000);
`endif
        out_ready = 1'b1;
        tick();
        req = 4'b0000; out_ready = 1'b0;
        tick();

        // Granted request dropped in HOLD
        do_reset();
        req = 4'b0010;
        wait_valid();
        check("t6_lfsr_hold", lfsr_state, 4'b1110);
        req = 4'b0000;
        tick();
        check("t6_valid", out_valid, 0);
        check("t6_grant", grant, 4'b0000);
        check("t6_busy", busy, 0);
        check("t6_lfsr", lfsr_state, 4'b1110);

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(7) == 0) req = 4'($urandom);
            out_ready = 1'($urandom);
            seed_load = ($urandom_range(19) == 0);
            seed      = 4'($urandom);
            reset     = ($urandom_range(99) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
